// File: rtl/rsa_stage_seq.sv
// Stage sequencer for the RSA systolic array: accepts a one-hot stage request, handshakes
// with the nonlinear unit, then runs P matrix-multiply passes of T cycles with skewed feed decodes.
module rsa_stage_seq #(
  parameter int X         = 4,
  parameter int Y         = 4,
  parameter int L         = 4,
  parameter int TB_AW     = 12,
  parameter int GROUP_LEN = 16,
  parameter int RD_DELAY  = 3,
  parameter int WR_DELAY  = 1
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic [2:0]            stage_val,
  output logic [2:0]            stage_rdy,
  input  logic [GROUP_LEN-1:0]  n_len,
  output logic [2:0]            nonlinear_val,
  input  logic [2:0]            nonlinear_rdy,
  output logic [X-1:0]          A_in_en,
  output logic [Y-1:0]          B_in_en,
  output logic [X-1:0]          C_out_en,
  output logic [L-1:0]          TB_ena,
  output logic [L*TB_AW-1:0]    TB_addra,
  output logic                  busy,
  output logic                  done
);

  // k must hold T-1 for the largest N the n_len field can express.
  localparam int TMAX = RD_DELAY + WR_DELAY + (2**GROUP_LEN - 1) + X + Y - 1;
  localparam int KW   = $clog2(TMAX);

  localparam logic [31:0] RD32  = 32'(RD_DELAY);
  localparam logic [31:0] WR32  = 32'(WR_DELAY);
  localparam logic [31:0] Y32   = 32'(Y);
  localparam logic [31:0] TFIX  = 32'(RD_DELAY + WR_DELAY + X + Y - 2);

  typedef enum logic [1:0] {S_IDLE, S_NONLIN, S_MULT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           stage_q, stage_d;
  logic [GROUP_LEN-1:0] n_q, n_d;
  logic [1:0]           pass_q, pass_d;
  logic [KW-1:0]        k_q, k_d;

  logic [31:0] k32, n32, t_last;
  logic [1:0]  pass_max;

  assign k32    = 32'(k_q);
  assign n32    = 32'(n_q);
  assign t_last = TFIX + n32;

  // PRD runs three passes, NEW one, UPD two.
  assign pass_max = stage_q[0] ? 2'd2 : (stage_q[2] ? 2'd1 : 2'd0);

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= S_IDLE;
      stage_q <= 3'b000;
      n_q     <= '0;
      pass_q  <= 2'd0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      n_q     <= n_d;
      pass_q  <= pass_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    n_d     = n_q;
    pass_d  = pass_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (stage_val inside {3'b001, 3'b010, 3'b100}) begin
          state_d = S_NONLIN;
          stage_d = stage_val;
          n_d     = (n_len == '0) ? {{(GROUP_LEN-1){1'b0}}, 1'b1} : n_len;
          pass_d  = 2'd0;
          k_d     = '0;
        end
      end
      S_NONLIN: begin
        if ((stage_q & nonlinear_rdy) != 3'b000) begin
          state_d = S_MULT;
          k_d     = '0;
        end
      end
      S_MULT: begin
        if (k32 == t_last) begin
          k_d = '0;
          if (pass_q != pass_max) pass_d = pass_q + 2'd1;
          else                    state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        pass_d  = 2'd0;
        k_d     = '0;
      end
    endcase
  end

  always_comb begin
    stage_rdy     = (state_q == S_IDLE) ? 3'b111 : 3'b000;
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    nonlinear_val = (state_q == S_NONLIN) ? stage_q : 3'b000;
    A_in_en       = '0;
    B_in_en       = '0;
    C_out_en      = '0;
    TB_ena        = '0;
    TB_addra      = '0;
    if (state_q == S_MULT) begin
      for (int l = 0; l < L; l++) begin
        if (k32 >= 32'(l) && k32 <= 32'(l) + n32 - 32'd1) begin
          TB_ena[l] = 1'b1;
          TB_addra[l*TB_AW +: TB_AW] = TB_AW'(32'(pass_q) * n32 + k32 - 32'(l));
        end
      end
      // Feed windows are offset by the TB read latency; compare on k to stay unsigned.
      for (int i = 0; i < X; i++) begin
        if (k32 >= 32'(i) + RD32 && k32 <= 32'(i) + RD32 + n32 - 32'd1)
          A_in_en[i] = 1'b1;
        if (k32 >= RD32 + n32 + 32'(i) + WR32 && k32 <= RD32 + n32 + 32'(i) + WR32 + Y32 - 32'd1)
          C_out_en[i] = 1'b1;
      end
      for (int j = 0; j < Y; j++) begin
        if (k32 >= 32'(j) + RD32 && k32 <= 32'(j) + RD32 + n32 - 32'd1)
          B_in_en[j] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rsa_stage_seq.sv
// Bench for rsa_stage_seq: table-driven and randomized stages checked cycle by cycle against a
// pass/k model derived from the MULT cycle index; a TB_AW=2 copy checks address wrap.
module tb_rsa_stage_seq;

  localparam int RD = 3;
  localparam int WR = 1;

  typedef struct packed {
    logic [2:0]  rdy;
    logic [2:0]  nlv;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  c;
    logic [3:0]  ena;
    logic [47:0] addr;
    logic [7:0]  addr2;
    logic        busy;
    logic        done;
  } obs_t;

  typedef struct {
    logic [2:0] st;
    int         n;
    int         hs;
    int         exp_mult;
  } vec_t;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [2:0]  stage_val, nonlinear_rdy;
  logic [15:0] n_len;

  logic [2:0]  stage_rdy, nonlinear_val, stage_rdy2, nonlinear_val2;
  logic [3:0]  A_in_en, B_in_en, C_out_en, TB_ena;
  logic [3:0]  A_in_en2, B_in_en2, C_out_en2, TB_ena2;
  logic [47:0] TB_addra;
  logic [7:0]  TB_addra2;
  logic        busy, done, busy2, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rsa_stage_seq #(.X(4), .Y(4), .L(4), .TB_AW(12), .GROUP_LEN(16), .RD_DELAY(RD), .WR_DELAY(WR)) dut (
    .clk(clk), .sys_rst(sys_rst), .stage_val(stage_val), .stage_rdy(stage_rdy), .n_len(n_len),
    .nonlinear_val(nonlinear_val), .nonlinear_rdy(nonlinear_rdy), .A_in_en(A_in_en),
    .B_in_en(B_in_en), .C_out_en(C_out_en), .TB_ena(TB_ena), .TB_addra(TB_addra),
    .busy(busy), .done(done));

  rsa_stage_seq #(.X(4), .Y(4), .L(4), .TB_AW(2), .GROUP_LEN(16), .RD_DELAY(RD), .WR_DELAY(WR)) dut2 (
    .clk(clk), .sys_rst(sys_rst), .stage_val(stage_val), .stage_rdy(stage_rdy2), .n_len(n_len),
    .nonlinear_val(nonlinear_val2), .nonlinear_rdy(nonlinear_rdy), .A_in_en(A_in_en2),
    .B_in_en(B_in_en2), .C_out_en(C_out_en2), .TB_ena(TB_ena2), .TB_addra(TB_addra2),
    .busy(busy2), .done(done2));

  function automatic int n_pass(input logic [2:0] st);
    case (st)
      3'b001:  return 3;
      3'b010:  return 1;
      default: return 2;
    endcase
  endfunction

  function automatic obs_t idle_obs();
    obs_t o = '0;
    o.rdy = 3'b111;
    return o;
  endfunction

  function automatic obs_t nonlin_obs(input logic [2:0] st);
    obs_t o = '0;
    o.nlv  = st;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic obs_t done_obs();
    obs_t o = '0;
    o.busy = 1'b1;
    o.done = 1'b1;
    return o;
  endfunction

  // m is the index of the cycle within the whole MULT phase of the stage.
  function automatic obs_t mult_obs(input int n, input int m);
    obs_t o = '0;
    int t, p, k, e, a, s;
    t = RD + WR + n + 4 + 4 - 1;
    p = m / t;
    k = m % t;
    e = k - RD;
    o.busy = 1'b1;
    for (int l = 0; l < 4; l++) begin
      if (k >= l && k <= l + n - 1) begin
        a = p * n + k - l;
        o.ena[l] = 1'b1;
        o.addr[l*12 +: 12] = 12'(a % 4096);
        o.addr2[l*2 +: 2]  = 2'(a % 4);
      end
    end
    for (int i = 0; i < 4; i++) begin
      s = RD + n + i + WR;
      o.a[i] = (e >= i && e <= i + n - 1);
      o.b[i] = (e >= i && e <= i + n - 1);
      o.c[i] = (k >= s && k <= s + 4 - 1);
    end
    return o;
  endfunction

  task automatic chk(input obs_t exp, input string name);
    obs_t act;
    logic [25:0] side, side_exp;
    act = '{rdy: stage_rdy, nlv: nonlinear_val, a: A_in_en, b: B_in_en, c: C_out_en,
            ena: TB_ena, addr: TB_addra, addr2: TB_addra2, busy: busy, done: done};
    side     = {stage_rdy2, nonlinear_val2, A_in_en2, B_in_en2, C_out_en2, TB_ena2, busy2, done2};
    side_exp = {exp.rdy, exp.nlv, exp.a, exp.b, exp.c, exp.ena, exp.busy, exp.done};
    checks++;
    if (act != exp || side != side_exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h/%h required %h/%h", name, $time, act, side, exp, side_exp);
    end
  endtask

  task automatic run_stage(input logic [2:0] st, input int n, input int hs, input int exp_mult);
    int nn;
    nn = (n == 0) ? 1 : n;
    chk(idle_obs(), "idle_pre");
    stage_val     = st;
    n_len         = 16'(n);
    nonlinear_rdy = 3'($urandom);
    for (int d = 0; d <= hs; d++) begin
      @(negedge clk);
      chk(nonlin_obs(st), "nonlin");
      stage_val     = 3'($urandom);
      n_len         = 16'($urandom);
      nonlinear_rdy = (d == hs) ? (st | 3'($urandom)) : (3'($urandom) & ~st);
    end
    for (int m = 0; m < exp_mult; m++) begin
      @(negedge clk);
      chk(mult_obs(nn, m), "mult");
      stage_val     = 3'($urandom);
      n_len         = 16'($urandom);
      nonlinear_rdy = 3'($urandom);
    end
    @(negedge clk);
    chk(done_obs(), "done");
    stage_val = 3'b001;
    n_len     = 16'd5;
    @(negedge clk);
    chk(idle_obs(), "idle_after_done");
    stage_val     = 3'b000;
    nonlinear_rdy = 3'b000;
    @(negedge clk);
    chk(idle_obs(), "done_req_ignored");
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{st: 3'b001, n: 3, hs: 4, exp_mult: 42};
    vecs[1] = '{st: 3'b010, n: 0, hs: 0, exp_mult: 12};
    vecs[2] = '{st: 3'b100, n: 2, hs: 1, exp_mult: 26};
    vecs[3] = '{st: 3'b010, n: 5, hs: 2, exp_mult: 16};
    vecs[4] = '{st: 3'b001, n: 0, hs: 0, exp_mult: 36};

    sys_rst       = 1'b0;
    stage_val     = 3'b000;
    nonlinear_rdy = 3'b000;
    n_len         = 16'd0;
    @(negedge clk);
    chk(idle_obs(), "reset_state");
    sys_rst = 1'b1;
    @(negedge clk);
    chk(idle_obs(), "after_release");

    stage_val = 3'b011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk(idle_obs(), "multibit_ignored");
    end
    stage_val = 3'b111;
    @(negedge clk);
    chk(idle_obs(), "all_ones_ignored");
    stage_val = 3'b000;
    @(negedge clk);
    chk(idle_obs(), "zero_ignored");

    for (int v = 0; v < 5; v++)
      run_stage(vecs[v].st, vecs[v].n, vecs[v].hs, vecs[v].exp_mult);

    // UPD N=2 (T=13) interrupted by reset at pass 1, k=5.
    stage_val = 3'b100;
    n_len     = 16'd2;
    @(negedge clk);
    chk(nonlin_obs(3'b100), "rst_seq_nonlin");
    stage_val     = 3'b000;
    nonlinear_rdy = 3'b100;
    for (int m = 0; m <= 18; m++) begin
      @(negedge clk);
      chk(mult_obs(2, m), "rst_seq_mult");
      nonlinear_rdy = 3'b000;
    end
    #2 sys_rst = 1'b0;
    #1 chk(idle_obs(), "async_reset");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk(idle_obs(), "held_reset_no_done");
    end
    sys_rst = 1'b1;
    @(negedge clk);
    chk(idle_obs(), "post_reset_idle");
    run_stage(3'b100, 2, 0, 26);

    for (int r = 0; r < 8; r++) begin
      logic [2:0] st;
      int n, nn;
      st = 3'b001 << $urandom_range(0, 2);
      n  = $urandom_range(0, 6);
      nn = (n == 0) ? 1 : n;
      run_stage(st, n, $urandom_range(0, 3), n_pass(st) * (RD + WR + nn + 4 + 4 - 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "timeout");
  end

endmodule
